// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to build the signed overflow flop; otherwise Ovf is tied low.
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] ss_q, ss_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             s_bit, c_out, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign s_bit    = sa_q[0] ^ sb_q[0] ^ c_q;
   assign c_out    = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ss_d    = ss_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
               sa_d    = A;
               sb_d    = B;
               c_d     = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            c_d   = c_out;
            sa_d  = {1'b0, sa_q[WIDTH-1:1]};
            sb_d  = {1'b0, sb_q[WIDTH-1:1]};
            ss_d  = {s_bit, ss_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            // The final bit publishes the result straight from the shift input.
            if (last_bit) begin
               sum_d   = {s_bit, ss_q[WIDTH-1:1]};
               cout_d  = c_out;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = c_q ^ c_out;
`endif
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ss_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ss_q    <= ss_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign Ovf = ovf_q;
`else
   assign Ovf = 1'b0;
`endif

   assign Busy = busy_q;
   assign Done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule
